// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg
//   Shared constants for the scoreboarded register file: default data and
//   address widths and the address of the hardwired-zero register.
//   No ports.
package regfile_sb_pkg;

    localparam int RF_DW = 32;
    localparam int RF_AW = 5;

    // Address of the hardwired-zero register, sliced to AW by the users.
    localparam logic [31:0] REG_ZERO = 32'd0;

endpackage : regfile_sb_pkg

// File: rtl/regfile_sb_if.sv
// regfile_sb_if
//   Bus bundle for regfile_sb: two combinational read ports with busy flags,
//   two write-back ports and one issue port.
//   Signals:
//     rna, rnb        read addresses, ports A/B
//     qa, qb          read data, ports A/B
//     busy_a, busy_b  scoreboard pending flag for rna / rnb
//     we0, wn0, d0    write port 0 (ALU writeback)
//     we1, wn1, d1    write port 1 (load writeback)
//     iss_en, iss_wn  issue port, marks iss_wn as awaiting a result
//   Modports: master (drives requests), slave (the register file).
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
) ();

    logic [AW-1:0] rna;
    logic [AW-1:0] rnb;
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;
    logic          busy_a;
    logic          busy_b;

    logic          we0;
    logic [AW-1:0] wn0;
    logic [DW-1:0] d0;
    logic          we1;
    logic [AW-1:0] wn1;
    logic [DW-1:0] d1;

    logic          iss_en;
    logic [AW-1:0] iss_wn;

    modport master (
        output rna, rnb,
        output we0, wn0, d0,
        output we1, wn1, d1,
        output iss_en, iss_wn,
        input  qa, qb, busy_a, busy_b
    );

    modport slave (
        input  rna, rnb,
        input  we0, wn0, d0,
        input  we1, wn1, d1,
        input  iss_en, iss_wn,
        output qa, qb, busy_a, busy_b
    );

endinterface : regfile_sb_if

// File: rtl/regfile_sb_score.sv
// regfile_sb_score
//   Busy scoreboard: one pending bit per register 1..2**AW-1. An issue sets
//   the bit, a committing write on either port clears it; issue wins over a
//   same-cycle write. Lookups for both read ports are combinational.
//   Ports:
//     clk, clr            clock, async active-high clear
//     iss_en, iss_wn      issue request
//     wc0, wn0            port 0 write commit (already qualified nonzero)
//     wc1, wn1            port 1 write commit (already qualified nonzero)
//     rna, rnb            lookup addresses
//     busy_a, busy_b      lookup results, forced 0 while clr is high
module regfile_sb_score
    import regfile_sb_pkg::*;
#(
    parameter int AW     = RF_AW,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_wn,
    input  logic          wc0,
    input  logic [AW-1:0] wn0,
    input  logic          wc1,
    input  logic [AW-1:0] wn1,
    input  logic [AW-1:0] rna,
    input  logic [AW-1:0] rnb,
    output logic          busy_a,
    output logic          busy_b
);

    localparam int            NREG = 2**AW;
    localparam logic [AW-1:0] R0   = REG_ZERO[AW-1:0];
    localparam bit            BYP  = (BYPASS != 0);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic hit_a, hit_b;
    logic iss_a, iss_b;

    // Clears first, set last: an issue landing with a write keeps the bit.
    always_comb begin
        busy_d = busy_q;
        if (wc0) busy_d[wn0] = 1'b0;
        if (wc1) busy_d[wn1] = 1'b0;
        if (iss_en && (iss_wn != R0)) busy_d[iss_wn] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        hit_a = (wc0 && (wn0 == rna)) || (wc1 && (wn1 == rna));
        hit_b = (wc0 && (wn0 == rnb)) || (wc1 && (wn1 == rnb));
        iss_a = iss_en && (iss_wn == rna);
        iss_b = iss_en && (iss_wn == rnb);
    end

    // With forwarding, a result arriving this cycle hides the pending flag
    // unless the same register is being re-issued in that cycle.
    assign busy_a = !clr && busy_q[rna] && !(BYP && hit_a && !iss_a);
    assign busy_b = !clr && busy_q[rnb] && !(BYP && hit_b && !iss_b);

endmodule : regfile_sb_score

// File: rtl/regfile_sb.sv
// regfile_sb
//   Register file with 2**AW entries of DW bits (entry 0 reads as zero),
//   two combinational read ports, two write-back ports (port 1 wins on a
//   same-address collision), optional same-cycle write forwarding, and a
//   busy scoreboard (regfile_sb_score).
//   Parameters: DW data width, AW address width, BYPASS 1 = forward writes.
//   Ports:
//     clk   single clock, rising edge
//     clr   asynchronous active-high clear of data and busy bits
//     bus   regfile_sb_if.slave (read, write, issue ports)
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DW     = RF_DW,
    parameter int AW     = RF_AW,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         clr,
    regfile_sb_if.slave  bus
);

    localparam int            NREG = 2**AW;
    localparam logic [AW-1:0] R0   = REG_ZERO[AW-1:0];

    logic          wc0, wc1;
    logic [DW-1:0] mem_q [NREG];
    logic [DW-1:0] mem_d [NREG];
    logic [DW-1:0] rd_a, rd_b;

    // A write only commits to a nonzero address, so entry 0 is never touched.
    assign wc0 = bus.we0 && (bus.wn0 != R0);
    assign wc1 = bus.we1 && (bus.wn1 != R0);

    // Port 1 is applied after port 0 so it wins a same-address collision.
    always_comb begin
        mem_d = mem_q;
        if (wc0) mem_d[bus.wn0] = bus.d0;
        if (wc1) mem_d[bus.wn1] = bus.d1;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_a = mem_q[bus.rna];
        rd_b = mem_q[bus.rnb];
        if (BYPASS != 0) begin
            if (wc1 && (bus.wn1 == bus.rna))      rd_a = bus.d1;
            else if (wc0 && (bus.wn0 == bus.rna)) rd_a = bus.d0;
            if (wc1 && (bus.wn1 == bus.rnb))      rd_b = bus.d1;
            else if (wc0 && (bus.wn0 == bus.rnb)) rd_b = bus.d0;
        end
    end

    // The forward path bypasses the cleared array, so gate it during clr.
    assign bus.qa = clr ? '0 : rd_a;
    assign bus.qb = clr ? '0 : rd_b;

    regfile_sb_score #(
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_score (
        .clk    (clk),
        .clr    (clr),
        .iss_en (bus.iss_en),
        .iss_wn (bus.iss_wn),
        .wc0    (wc0),
        .wn0    (bus.wn0),
        .wc1    (wc1),
        .wn1    (bus.wn1),
        .rna    (bus.rna),
        .rnb    (bus.rnb),
        .busy_a (bus.busy_a),
        .busy_b (bus.busy_b)
    );

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
    import regfile_sb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    regfile_sb_if #(.DW(DW), .AW(AW)) bus_b ();
    regfile_sb_if #(.DW(DW), .AW(AW)) bus_n ();

    regfile_sb #(.DW(DW), .AW(AW), .BYPASS(1)) dut_b (.clk(clk), .clr(clr), .bus(bus_b));
    regfile_sb #(.DW(DW), .AW(AW), .BYPASS(0)) dut_n (.clk(clk), .clr(clr), .bus(bus_n));

    // The no-forwarding instance sees exactly the same requests.
    assign bus_n.rna    = bus_b.rna;
    assign bus_n.rnb    = bus_b.rnb;
    assign bus_n.we0    = bus_b.we0;
    assign bus_n.wn0    = bus_b.wn0;
    assign bus_n.d0     = bus_b.d0;
    assign bus_n.we1    = bus_b.we1;
    assign bus_n.wn1    = bus_b.wn1;
    assign bus_n.d1     = bus_b.d1;
    assign bus_n.iss_en = bus_b.iss_en;
    assign bus_n.iss_wn = bus_b.iss_wn;

    int n_chk = 0;
    int n_err = 0;

    // Reference: architectural register contents and pending set.
    logic [31:0] m_reg  [N];
    bit          m_busy [N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < N; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic bit wr_hits(input int port, input int addr);
        if (addr == 0) return 1'b0;
        if (port == 0) return bus_b.we0 && (int'(bus_b.wn0) == addr);
        return bus_b.we1 && (int'(bus_b.wn1) == addr);
    endfunction

    function automatic logic [31:0] exp_q(input bit byp, input int addr);
        if (clr) return '0;
        if (byp) begin
            if (wr_hits(1, addr)) return bus_b.d1;
            if (wr_hits(0, addr)) return bus_b.d0;
        end
        return m_reg[addr];
    endfunction

    function automatic logic [31:0] exp_busy(input bit byp, input int addr);
        bit pend;
        if (clr) return '0;
        pend = m_busy[addr];
        if (byp && (wr_hits(0, addr) || wr_hits(1, addr))
            && !(bus_b.iss_en && int'(bus_b.iss_wn) == addr))
            pend = 1'b0;
        return {31'd0, pend};
    endfunction

    task automatic check_all();
        int a, b;
        a = int'(bus_b.rna);
        b = int'(bus_b.rnb);
        chk("qa_byp",     bus_b.qa,     exp_q(1'b1, a));
        chk("qb_byp",     bus_b.qb,     exp_q(1'b1, b));
        chk("busy_a_byp", bus_b.busy_a, exp_busy(1'b1, a));
        chk("busy_b_byp", bus_b.busy_b, exp_busy(1'b1, b));
        chk("qa_nobyp",     bus_n.qa,     exp_q(1'b0, a));
        chk("qb_nobyp",     bus_n.qb,     exp_q(1'b0, b));
        chk("busy_a_nobyp", bus_n.busy_a, exp_busy(1'b0, a));
        chk("busy_b_nobyp", bus_n.busy_b, exp_busy(1'b0, b));
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        if (!clr) begin
            if (wr_hits(0, int'(bus_b.wn0))) begin
                m_reg[bus_b.wn0]  = bus_b.d0;
                m_busy[bus_b.wn0] = 1'b0;
            end
            if (wr_hits(1, int'(bus_b.wn1))) begin
                m_reg[bus_b.wn1]  = bus_b.d1;
                m_busy[bus_b.wn1] = 1'b0;
            end
            if (bus_b.iss_en && bus_b.iss_wn != '0) m_busy[bus_b.iss_wn] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus_b.rna = '0;  bus_b.rnb = '0;
        bus_b.we0 = 1'b0; bus_b.wn0 = '0; bus_b.d0 = '0;
        bus_b.we1 = 1'b0; bus_b.wn1 = '0; bus_b.d1 = '0;
        bus_b.iss_en = 1'b0; bus_b.iss_wn = '0;
    endtask

    initial begin
        clr = 1'b1;
        idle();
        mdl_clear();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_qa",     bus_b.qa,     32'h0);
        chk("rst_busy_a", bus_b.busy_a, 32'h0);
        clr = 1'b0;
        @(negedge clk);

        // Plain write on port 0, read back next cycle.
        idle();
        bus_b.we0 = 1'b1; bus_b.wn0 = 5'd5; bus_b.d0 = 32'h12345678; bus_b.rna = 5'd5;
        step();
        idle();
        bus_b.rna = 5'd5;
        #1;
        chk("r5_qa",       bus_b.qa,     32'h12345678);
        chk("r5_busy_a",   bus_b.busy_a, 32'h0);
        chk("r5_qa_nobyp", bus_n.qa,     32'h12345678);
        step();

        // Dual write collision: port 1 wins, forwarded only with bypass.
        idle();
        bus_b.we0 = 1'b1; bus_b.wn0 = 5'd7; bus_b.d0 = 32'hAAAA0000;
        bus_b.we1 = 1'b1; bus_b.wn1 = 5'd7; bus_b.d1 = 32'h5555FFFF;
        bus_b.rna = 5'd7; bus_b.rnb = 5'd7;
        #1;
        chk("coll_qa_byp",   bus_b.qa, 32'h5555FFFF);
        chk("coll_qb_byp",   bus_b.qb, 32'h5555FFFF);
        chk("coll_qa_nobyp", bus_n.qa, 32'h0);
        step();
        idle();
        bus_b.rna = 5'd7;
        #1;
        chk("coll_after_byp",   bus_b.qa, 32'h5555FFFF);
        chk("coll_after_nobyp", bus_n.qa, 32'h5555FFFF);
        step();

        // Writes to r0 are dropped.
        idle();
        bus_b.we0 = 1'b1; bus_b.wn0 = 5'd0; bus_b.d0 = 32'hFFFFFFFF;
        bus_b.we1 = 1'b1; bus_b.wn1 = 5'd0; bus_b.d1 = 32'hFFFFFFFF;
        bus_b.iss_en = 1'b1; bus_b.iss_wn = 5'd0;
        #1;
        chk("r0_qa_during", bus_b.qa,     32'h0);
        chk("r0_busy_a",    bus_b.busy_a, 32'h0);
        step();
        idle();
        #1;
        chk("r0_qa_after",   bus_b.qa,     32'h0);
        chk("r0_busy_after", bus_b.busy_a, 32'h0);
        step();

        // Scoreboard: issue, write-back clears, issue+write keeps busy.
        idle();
        bus_b.iss_en = 1'b1; bus_b.iss_wn = 5'd3;
        step();
        idle();
        bus_b.rna = 5'd3;
        #1;
        chk("r3_busy",       bus_b.busy_a, 32'h1);
        chk("r3_busy_nobyp", bus_n.busy_a, 32'h1);
        step();
        idle();
        bus_b.rna = 5'd3; bus_b.we1 = 1'b1; bus_b.wn1 = 5'd3; bus_b.d1 = 32'h10;
        #1;
        chk("r3_wb_busy",       bus_b.busy_a, 32'h0);
        chk("r3_wb_qa",         bus_b.qa,     32'h10);
        chk("r3_wb_busy_nobyp", bus_n.busy_a, 32'h1);
        step();
        idle();
        bus_b.rna = 5'd3;
        #1;
        chk("r3_clr_busy_nobyp", bus_n.busy_a, 32'h0);
        step();
        idle();
        bus_b.rna = 5'd3; bus_b.iss_en = 1'b1; bus_b.iss_wn = 5'd3;
        bus_b.we0 = 1'b1; bus_b.wn0 = 5'd3; bus_b.d0 = 32'h20;
        step();
        idle();
        bus_b.rna = 5'd3;
        #1;
        chk("r3_iss_wr_busy", bus_b.busy_a, 32'h1);
        chk("r3_iss_wr_qa",   bus_b.qa,     32'h20);
        step();

        // Asynchronous clear in the middle of a cycle.
        idle();
        bus_b.we1 = 1'b1; bus_b.wn1 = 5'd9; bus_b.d1 = 32'hDEAD;
        bus_b.iss_en = 1'b1; bus_b.iss_wn = 5'd9;
        step();
        idle();
        bus_b.rna = 5'd9;
        #1;
        chk("r9_qa",   bus_b.qa,     32'hDEAD);
        chk("r9_busy", bus_b.busy_a, 32'h1);
        #2;
        clr = 1'b1;
        mdl_clear();
        #1;
        chk("clr_qa",         bus_b.qa,     32'h0);
        chk("clr_busy_a",     bus_b.busy_a, 32'h0);
        chk("clr_qa_nobyp",   bus_n.qa,     32'h0);
        @(posedge clk);
        @(negedge clk);
        bus_b.we0 = 1'b1; bus_b.wn0 = 5'd9; bus_b.d0 = 32'h1234;
        bus_b.iss_en = 1'b1; bus_b.iss_wn = 5'd9;
        bus_b.rnb = 5'd9;
        #1;
        chk("clr_fwd_qb",   bus_b.qb,     32'h0);
        chk("clr_busy_b",   bus_b.busy_b, 32'h0);
        step();
        clr = 1'b0;
        idle();
        bus_b.rna = 5'd9;
        #1;
        chk("r9_after_clr",      bus_b.qa,     32'h0);
        chk("r9_busy_after_clr", bus_b.busy_a, 32'h0);
        step();

        // Random traffic on a narrow address window to force collisions.
        for (int c = 0; c < 400; c++) begin
            bus_b.rna    = AW'($urandom_range(0, 7));
            bus_b.rnb    = AW'($urandom_range(0, 7));
            bus_b.we0    = ($urandom_range(0, 1) == 1);
            bus_b.wn0    = AW'($urandom_range(0, 7));
            bus_b.d0     = $urandom;
            bus_b.we1    = ($urandom_range(0, 2) == 0);
            bus_b.wn1    = AW'($urandom_range(0, 7));
            bus_b.d1     = $urandom;
            bus_b.iss_en = ($urandom_range(0, 2) == 0);
            bus_b.iss_wn = AW'($urandom_range(0, 7));
            step();
        end

        // Sweep every register once to confirm final contents.
        idle();
        for (int r = 0; r < N; r++) begin
            bus_b.rna = AW'(r);
            bus_b.rnb = AW'(N - 1 - r);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_regfile_sb

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DW, default 32, data width in bits.
REQ-002 Parameter AW, default 5, address width; depth is 2**AW registers, entry 0 hardwired zero.
REQ-003 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = reads return pre-edge contents.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 clr  in  1  reset, asynchronous, active-high.
REQ-006 rna, rnb  in  AW  read addresses, ports A and B.
REQ-007 qa, qb  out  DW  read data, ports A and B, combinational.
REQ-008 busy_a, busy_b  out  1  scoreboard pending flag for rna / rnb, combinational.
REQ-009 we0, wn0, d0  in  1/AW/DW  write port 0 (ALU writeback): enable, address, data.
REQ-010 we1, wn1, d1  in  1/AW/DW  write port 1 (load writeback): enable, address, data.
REQ-011 iss_en, iss_wn  in  1/AW  issue port: marks register iss_wn as awaiting a result.

Function
REQ-012 Register 0 SHALL read as 0 and SHALL never be written or marked busy.
REQ-013 A write SHALL commit at the rising edge when its enable is 1 and its address is nonzero.
REQ-014 When both write ports target the same nonzero address in one cycle, port 1 SHALL win and port 0's data SHALL be discarded.
REQ-015 With BYPASS=1, a read whose address matches an active nonzero write in the same cycle SHALL return that write's data (port 1 over port 0), else the stored value.
REQ-016 With BYPASS=0, reads SHALL return the stored value only; new data is visible one cycle after the write edge.
REQ-017 Scoreboard: one busy bit per register 1..2**AW-1.
REQ-018 A busy bit SHALL be set at the edge on iss_en with iss_wn nonzero.
REQ-019 A busy bit SHALL be cleared at the edge by any committing write to that register on either port.
REQ-020 Issue and write to the same register in one cycle: set SHALL win; the bit ends at 1 and the data is still committed.
REQ-021 Issue to an already-busy register SHALL leave it busy; a write to a non-busy register SHALL commit normally with the bit staying 0.
REQ-022 busy_a SHALL equal busy[rna]; with BYPASS=1 it SHALL be 0 when a write to rna commits this cycle and no same-cycle issue targets rna.
REQ-023 busy_b SHALL follow REQ-022 with rnb.
REQ-024 Read latency SHALL be zero cycles, write latency one edge, scoreboard update one edge.

Reset
REQ-025 Asserting clr SHALL asynchronously clear all registers and all busy bits to 0, without waiting for clk.
REQ-026 While clr=1, qa, qb, busy_a and busy_b SHALL read 0 and writes and issues SHALL be ignored.
REQ-027 A write or issue coinciding with the edge at which clr deasserts SHALL take effect normally.

Structure
REQ-028 A shared package SHALL hold the DW/AW defaults and the register-0 address constant.
REQ-029 The scoreboard SHALL be one sub-module, regfile_sb_score (busy vector, set/clear logic, busy lookups); the storage array and bypass muxing remain in regfile_sb.

Verification
REQ-030 Reset, write r5=0x12345678 via port 0, next cycle rna=5 -> qa=0x12345678, busy_a=0.
REQ-031 BYPASS=1, same cycle we0 r7=0xAAAA0000 and we1 r7=0x5555FFFF with rna=rnb=7 -> qa=qb=0x5555FFFF that cycle and r7=0x5555FFFF afterwards; BYPASS=0 -> old value that cycle.
REQ-032 Write 0xFFFFFFFF to r0 on both ports with rna=0 -> qa=0 during and after the edge, busy_a=0.
REQ-033 Issue r3, next cycle rna=3 -> busy_a=1; write r3=0x10 via port 1 -> busy_a=0 in that cycle (BYPASS=1) and qa=0x10; issue and write r3 in one cycle -> busy_a=1 after the edge.
REQ-034 Load r9=0xDEAD and issue r9, assert clr mid-cycle -> immediately qa=0 and busy_a=0 for rna=9 with no clock edge; after release r9 reads 0.
